ahb_master_req_gen: RTL and testbench

- Master-side counterpart of the per-slave AHB arbiter: turns a single-command interface into an AHB request/burst sequence.
- Drives hreq and holds it for the full burst; waits for hgrant, then issues NONSEQ/SEQ beats with burst-correct address stepping.
- Releases hreq after the last beat is accepted, so the arbiter's beat monitor and its own counter agree on burst end.
- One instance per master port, between the master core and the interconnect.

---
 rtl/ahb_master_req_gen_pkg.sv | 42 ++++
 rtl/ahb_addr_step.sv | 36 +++
 rtl/ahb_master_req_gen.sv | 127 ++++++++++++
 tb/tb_ahb_master_req_gen.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_master_req_gen_pkg.sv
// Shared AHB types for the master request generator.
// Burst/transfer encodings and the burst length helper.
package ahb_master_req_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_type;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2
  } state_t;

  // Index of the last beat (beats-1); INCR is a single beat.
  function automatic logic [3:0] burst_beats(hburst_type b);
    logic [3:0] lim;
    lim = 4'd0;
    unique case (b)
      WRAP4, INCR4:   lim = 4'd3;
      WRAP8, INCR8:   lim = 4'd7;
      WRAP16, INCR16: lim = 4'd15;
      default:        lim = 4'd0;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/ahb_addr_step.sv
// Next beat address for an AHB burst.
// WRAP bursts only advance the bits below the wrap boundary.
module ahb_addr_step
  import ahb_master_req_gen_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  hburst_type        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] sum;
  logic [ADDR_W-1:0] mask;
  logic [4:0]        wbits;
  logic              wrap;

  // Boundary bits = log2(beats) + size; mask keeps the wrapping field.
  always_comb begin
    step  = ADDR_W'(1) << size;
    sum   = addr + step;
    wrap  = 1'b1;
    wbits = 5'(size);
    unique case (burst)
      WRAP4:   wbits = 5'(size) + 5'd2;
      WRAP8:   wbits = 5'(size) + 5'd3;
      WRAP16:  wbits = 5'(size) + 5'd4;
      default: wrap  = 1'b0;
    endcase
    mask      = ~({ADDR_W{1'b1}} << wbits);
    next_addr = wrap ? ((addr & ~mask) | (sum & mask)) : sum;
  end

endmodule

// File: rtl/ahb_master_req_gen.sv
// AHB master request generator: one command in, one
// arbitrated request plus NONSEQ/SEQ burst out.
module ahb_master_req_gen
  import ahb_master_req_gen_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_SIZE = 2
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  hburst_type        cmd_burst,
  input  logic [2:0]        cmd_size,
  output logic              hreq,
  input  logic              hgrant,
  input  logic              hwait,
  output logic [ADDR_W-1:0] haddr,
  output htrans_type        htrans,
  output logic              hwrite,
  output hburst_type        hburst,
  output logic [2:0]        hsize,
  output logic              beat_done,
  output logic              xfer_done
);

  localparam logic [2:0] MAX_SZ = 3'(MAX_SIZE);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  hburst_type        burst_q, burst_d;
  logic [2:0]        size_q, size_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] next_addr;

  ahb_addr_step #(
    .ADDR_W (ADDR_W)
  ) u_step (
    .addr      (addr_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  assign haddr  = addr_q;
  assign hwrite = write_q;
  assign hburst = burst_q;
  assign hsize  = size_q;

  // State and captured command registers.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      burst_q <= SINGLE;
      size_q  <= 3'd0;
      cnt_q   <= 4'd0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      burst_q <= burst_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // Next state, beat bookkeeping and handshake outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    burst_d   = burst_q;
    size_d    = size_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    cmd_ready = 1'b0;
    hreq      = 1'b0;
    htrans    = IDLE;
    beat_done = 1'b0;
    xfer_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          write_d = cmd_write;
          burst_d = cmd_burst;
          size_d  = (cmd_size > MAX_SZ) ? MAX_SZ : cmd_size;
          cnt_d   = 4'd0;
          first_d = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        hreq = 1'b1;
        if (hgrant) state_d = S_XFER;
      end
      S_XFER: begin
        hreq   = 1'b1;
        htrans = first_q ? NONSEQ : SEQ;
        if (hgrant) begin
          beat_done = 1'b1;
          addr_d    = next_addr;
          cnt_d     = cnt_q + 4'd1;
          first_d   = 1'b0;
          if (cnt_q == burst_beats(burst_q)) begin
            xfer_done = 1'b1;
            state_d   = S_IDLE;
          end
        end else if (!hwait) begin
          first_d = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ahb_master_req_gen.sv
// Bench for ahb_master_req_gen: directed scenarios plus random
// commands checked against an address-list reference model.
module tb_ahb_master_req_gen;
  import ahb_master_req_gen_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  hburst_type  cmd_burst;
  logic [2:0]  cmd_size;
  logic        hreq;
  logic        hgrant;
  logic        hwait;
  logic [31:0] haddr;
  htrans_type  htrans;
  logic        hwrite;
  hburst_type  hburst;
  logic [2:0]  hsize;
  logic        beat_done;
  logic        xfer_done;

  int n_pass = 0;
  int n_chk  = 0;
  logic [1:0] script[$];

  always #5 hclk = ~hclk;

  ahb_master_req_gen #(.ADDR_W(32), .MAX_SIZE(2)) dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_write(cmd_write),
    .cmd_burst(cmd_burst), .cmd_size(cmd_size),
    .hreq(hreq), .hgrant(hgrant), .hwait(hwait),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hburst(hburst), .hsize(hsize),
    .beat_done(beat_done), .xfer_done(xfer_done)
  );

  // Arbiter/slave response for one cycle: 0 always grant,
  // 1 random, 2 scripted (grant once the script runs out).
  task automatic pick(input int mode, output logic g, output logic w);
    logic [1:0] p;
    g = 1'b1;
    w = 1'b0;
    if (mode == 1) begin
      g = ($urandom_range(0, 99) < 60);
      w = 1'($urandom_range(0, 1));
    end else if (mode == 2 && script.size() > 0) begin
      p = script.pop_front();
      g = p[1];
      w = p[0];
    end
  endtask

  // Issue one command and follow it to completion against the model.
  task automatic do_cmd(input logic [31:0] a, input logic wr,
                        input hburst_type b, input logic [2:0] sz,
                        input int mode, output int hreq_cyc);
    logic [31:0] exp_a[$];
    logic [31:0] cur, step, bnd, low;
    logic [2:0]  esz;
    logic        g, w, wrap, granted, first;
    int          n, beat, budget;
    esz = (sz > 3'd2) ? 3'd2 : sz;
    step = 32'd1 << esz;
    case (b)
      WRAP4, INCR4:   n = 4;
      WRAP8, INCR8:   n = 8;
      WRAP16, INCR16: n = 16;
      default:        n = 1;
    endcase
    wrap = (b == WRAP4 || b == WRAP8 || b == WRAP16);
    cur = a;
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(cur);
      if (wrap) begin
        bnd = step * n;
        low = cur % bnd;
        cur = cur - low + ((low + step) % bnd);
      end else begin
        cur = cur + step;
      end
    end
    hreq_cyc = 0;
    @(negedge hclk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = wr;
    cmd_burst = b; cmd_size = sz; hgrant = 1'b0; hwait = 1'b0;
    #1;
    n_chk++;
    if (cmd_ready !== 1'b1 || hreq !== 1'b0)
      $display("FAIL accept ready=%b hreq=%b exp 1/0", cmd_ready, hreq);
    else n_pass++;
    @(posedge hclk);
    beat = 0; granted = 1'b0; first = 1'b1; budget = 400;
    while (beat < n && budget > 0) begin
      @(negedge hclk);
      budget--;
      pick(mode, g, w);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_addr = $urandom;
      cmd_burst = hburst_type'($urandom_range(0, 7));
      hgrant = g; hwait = w;
      #1;
      if (hreq === 1'b1) hreq_cyc++;
      if (!granted) begin
        n_chk++;
        if (hreq !== 1'b1 || htrans !== IDLE || beat_done !== 1'b0 ||
            cmd_ready !== 1'b0)
          $display("FAIL req hreq=%b htrans=%0d bd=%b rdy=%b exp 1/0/0/0",
                   hreq, htrans, beat_done, cmd_ready);
        else n_pass++;
        if (g) granted = 1'b1;
      end else begin
        n_chk++;
        if (htrans !== (first ? NONSEQ : SEQ))
          $display("FAIL htrans beat %0d got %0d exp %0d", beat, htrans,
                   first ? NONSEQ : SEQ);
        else n_pass++;
        n_chk++;
        if (haddr !== exp_a[beat])
          $display("FAIL haddr beat %0d got %h exp %h", beat, haddr, exp_a[beat]);
        else n_pass++;
        n_chk++;
        if (hwrite !== wr || hburst !== b || hsize !== esz || hreq !== 1'b1)
          $display("FAIL ctrl w=%b b=%0d s=%0d r=%b exp %b/%0d/%0d/1",
                   hwrite, hburst, hsize, hreq, wr, b, esz);
        else n_pass++;
        n_chk++;
        if (beat_done !== g || xfer_done !== (g && beat == n - 1))
          $display("FAIL done beat %0d bd=%b xd=%b exp %b/%b", beat,
                   beat_done, xfer_done, g, g && beat == n - 1);
        else n_pass++;
        if (g) begin
          beat++;
          first = 1'b0;
        end else if (!w) begin
          granted = 1'b0;
          first = 1'b1;
        end
      end
      @(posedge hclk);
    end
    #1;
    cmd_valid = 1'b0;
    hgrant = 1'b0;
    if (beat < n) begin
      n_chk++;
      $display("FAIL timeout beats %0d exp %0d", beat, n);
    end
  endtask

  task automatic test_reset();
    hreset_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
    cmd_burst = SINGLE; cmd_size = 3'd0; hgrant = 1'b0; hwait = 1'b0;
    repeat (3) @(negedge hclk);
    n_chk++;
    if (hreq !== 1'b0 || htrans !== IDLE || haddr !== 32'd0 ||
        hwrite !== 1'b0 || hburst !== SINGLE || hsize !== 3'd0 ||
        beat_done !== 1'b0 || xfer_done !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL reset r=%b t=%0d a=%h w=%b b=%0d s=%0d bd=%b xd=%b rdy=%b",
               hreq, htrans, haddr, hwrite, hburst, hsize, beat_done,
               xfer_done, cmd_ready);
    else n_pass++;
    hreset_n = 1'b1;
    @(negedge hclk);
  endtask

  task automatic test_single();
    int hc;
    script = '{2'b00, 2'b10, 2'b10};
    do_cmd(32'h100, 1'b1, SINGLE, 3'd0, 2, hc);
    n_chk++;
    if (hc !== 3) $display("FAIL single_hreq_cycles got %0d exp 3", hc);
    else n_pass++;
    @(negedge hclk);
    #1;
    n_chk++;
    if (hreq !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL single_after hreq=%b rdy=%b exp 0/1", hreq, cmd_ready);
    else n_pass++;
  endtask

  task automatic test_incr4();
    int hc;
    do_cmd(32'h20, 1'b0, INCR4, 3'd2, 0, hc);
    n_chk++;
    if (hc !== 5) $display("FAIL incr4_hreq_cycles got %0d exp 5", hc);
    else n_pass++;
  endtask

  task automatic test_wrap4();
    int hc;
    do_cmd(32'h38, 1'b1, WRAP4, 3'd2, 0, hc);
  endtask

  task automatic test_wait();
    int hc;
    script = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
    do_cmd(32'h40, 1'b0, INCR8, 3'd2, 2, hc);
    n_chk++;
    if (hc !== 12) $display("FAIL wait_hreq_cycles got %0d exp 12", hc);
    else n_pass++;
  endtask

  task automatic test_grant_loss();
    int hc;
    script = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10};
    do_cmd(32'h0, 1'b1, INCR4, 3'd2, 2, hc);
    n_chk++;
    if (hc !== 8) $display("FAIL loss_hreq_cycles got %0d exp 8", hc);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int hc;
    do_cmd(32'hFFFF_FFF8, 1'b1, INCR4, 3'd2, 0, hc);
    do_cmd(32'h0000_1234, 1'b0, WRAP8, 3'd1, 0, hc);
    do_cmd(32'h0000_0ABC, 1'b1, INCR, 3'd7, 0, hc);
  endtask

  task automatic test_random();
    int hc;
    for (int i = 0; i < 40; i++) begin
      do_cmd($urandom, 1'($urandom_range(0, 1)),
             hburst_type'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 1, hc);
      if ($urandom_range(0, 3) == 0) @(negedge hclk);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge hclk);
    cmd_valid = 1'b1; cmd_addr = 32'h1000; cmd_write = 1'b1;
    cmd_burst = INCR16; cmd_size = 3'd2; hgrant = 1'b1; hwait = 1'b0;
    @(negedge hclk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge hclk);
    #1;
    n_chk++;
    if (haddr !== 32'h1010 || htrans !== SEQ)
      $display("FAIL mid_beat5 a=%h t=%0d exp 00001010/%0d", haddr, htrans, SEQ);
    else n_pass++;
    hreset_n = 1'b0;
    #1;
    n_chk++;
    if (hreq !== 1'b0 || htrans !== IDLE || haddr !== 32'd0 ||
        hwrite !== 1'b0 || hburst !== SINGLE || hsize !== 3'd0 ||
        beat_done !== 1'b0 || xfer_done !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL mid_reset r=%b t=%0d a=%h w=%b b=%0d s=%0d bd=%b rdy=%b",
               hreq, htrans, haddr, hwrite, hburst, hsize, beat_done, cmd_ready);
    else n_pass++;
    @(negedge hclk);
    hreset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge hclk);
      #1;
      n_chk++;
      if (cmd_ready !== 1'b1 || hreq !== 1'b0 || beat_done !== 1'b0 ||
          htrans !== IDLE)
        $display("FAIL post_reset rdy=%b hreq=%b bd=%b t=%0d exp 1/0/0/0",
                 cmd_ready, hreq, beat_done, htrans);
      else n_pass++;
    end
    hgrant = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr4();
    test_wrap4();
    test_wait();
    test_grant_loss();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
